// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction sequencer issuing operands to a clocked 4-bit ALU
//
// Fetches 16-bit words from a loadable program memory, decodes them into ALU
// opcode/operands/carry-in, waits ALU_LAT edges, then writes the ALU result
// into a 4x4-bit register file and the carry-out into carry_flag.
//
// Word layout: [15:13] op, [12:11] dst, [10:9] src1, [8:7] src0,
//              [6] use_imm, [5:2] imm4, [1] cin_sel, [0] halt.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start / busy / done           run control and status
//   prog_we, prog_addr, prog_data program memory write port (IDLE only)
//   alu_instr, alu_in1, alu_in0, alu_cin   operands issued to the ALU
//   alu_out, alu_cout             ALU result returned after ALU_LAT edges
//   carry_flag, pc_out            architectural status
//   dbg_sel / dbg_reg             combinational register-file read
//   step                          only with SINGLE_STEP_EN: leaves PAUSE
//
// Optional feature macro: SINGLE_STEP_EN (adds step input and PAUSE state).

module alu_issue_ctrl #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic [2:0]    alu_instr,
  output logic [3:0]    alu_in1,
  output logic [3:0]    alu_in0,
  output logic          alu_cin,
  input  logic [3:0]    alu_out,
  input  logic          alu_cout,
  output logic          carry_flag,
  output logic [AW-1:0] pc_out,
  input  logic [1:0]    dbg_sel,
  output logic [3:0]    dbg_reg
`ifdef SINGLE_STEP_EN
  ,
  input  logic          step
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
`ifdef SINGLE_STEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    wait_q, wait_d;

  logic [15:0]   mem_q [DEPTH];
  logic [3:0]    rf_q [4];
  logic          carry_q;
  logic [1:0]    ir_dst_q;
  logic          ir_halt_q;
  logic [2:0]    alu_instr_q;
  logic [3:0]    alu_in1_q;
  logic [3:0]    alu_in0_q;
  logic          alu_cin_q;

  logic [15:0]   fetch_w;
  assign fetch_w = mem_q[pc_q];

  // Program memory has no reset; loading is only allowed while idle.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (ALU_LAT == 1) begin
          state_d = S_WB;
        end else begin
          // WAIT spans ALU_LAT-1 cycles; it exits when the counter reads zero.
          wait_d  = 3'(ALU_LAT - 2);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = S_WB;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_WB: begin
        if (ir_halt_q || pc_q == AW'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + AW'(1);
`ifdef SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      wait_q      <= '0;
      carry_q     <= 1'b0;
      ir_dst_q    <= '0;
      ir_halt_q   <= 1'b0;
      alu_instr_q <= '0;
      alu_in1_q   <= '0;
      alu_in0_q   <= '0;
      alu_cin_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      // Operands are captured on the edge entering ISSUE straight from the
      // fetched word, so the ALU sees them for the whole ISSUE cycle.
      if (state_q == S_FETCH) begin
        alu_instr_q <= fetch_w[15:13];
        alu_in1_q   <= rf_q[fetch_w[10:9]];
        alu_in0_q   <= fetch_w[6] ? fetch_w[5:2] : rf_q[fetch_w[8:7]];
        alu_cin_q   <= fetch_w[1] & carry_q;
        ir_dst_q    <= fetch_w[12:11];
        ir_halt_q   <= fetch_w[0];
      end
      if (state_q == S_WB) begin
        rf_q[ir_dst_q] <= alu_out;
        carry_q        <= alu_cout;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign alu_instr  = alu_instr_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in0    = alu_in0_q;
  assign alu_cin    = alu_cin_q;
  assign carry_flag = carry_q;
  assign pc_out     = pc_q;
  assign dbg_reg    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl at ALU_LAT 1 and 3

module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] in1;
    logic [3:0] in0;
    logic       cin;
  } iss_t;

  typedef struct packed {
    logic [15:0] rf;
    logic        c;
    logic [3:0]  pc;
    int          n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_pe = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b1;
  localparam int PS = 1;
`else
  localparam int PS = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) rst_pe <= rst;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [16];
  logic [3:0]  mrf [4];
  logic        mc;
  iss_t        iss_q [2][$];
  res_t        res_q [2][$];
  bit          done_seen [2];

  logic       busy_w [2];
  logic       done_w [2];
  logic [2:0] instr_w [2];
  logic [3:0] in1_w [2];
  logic [3:0] in0_w [2];
  logic       cin_w [2];
  logic [3:0] aout_w [2];
  logic       acout_w [2];
  logic       cf_w [2];
  logic [3:0] pc_w [2];
  logic [1:0] dbg_sel_w [2];
  logic [3:0] dbg_w [2];

  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic ci);
    if (op == 3'b001) return {1'b0, a} + {1'b0, b} + {4'b0, ci};
    return {^a, a ^ b};
  endfunction

  function automatic logic [15:0] enc(input int op, input int dst, input int s1, input int s0,
                                      input int imm, input int imm4, input int cs, input int halt);
    return {op[2:0], dst[1:0], s1[1:0], s0[1:0], imm[0], imm4[3:0], cs[0], halt[0]};
  endfunction

  task automatic chk(input string name, input int lat, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (lat %0d): actual=%0h required=%0h", name, lat, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int lat);
    tests++;
    fails++;
    $display("FAIL %s (lat %0d): actual=event required=none", name, lat);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    localparam int P = L + 2 + PS;

    // Clocked ALU model: operands captured each edge, result valid L edges later.
    logic [4:0] pipe [L];
    initial for (int k = 0; k < L; k++) pipe[k] = '0;
    always @(posedge clk) begin
      pipe[0] <= alu_f(instr_w[g], in1_w[g], in0_w[g], cin_w[g]);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign aout_w[g]  = pipe[L-1][3:0];
    assign acout_w[g] = pipe[L-1][4];

    alu_issue_ctrl #(.DEPTH(16), .AW(4), .ALU_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy_w[g]), .done(done_w[g]),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .alu_instr(instr_w[g]), .alu_in1(in1_w[g]), .alu_in0(in0_w[g]), .alu_cin(cin_w[g]),
      .alu_out(aout_w[g]), .alu_cout(acout_w[g]), .carry_flag(cf_w[g]), .pc_out(pc_w[g]),
      .dbg_sel(dbg_sel_w[g]), .dbg_reg(dbg_w[g])
`ifdef SINGLE_STEP_EN
      , .step(step)
`endif
    );

    initial begin : mon
      int          cyc;
      bit          run;
      bit          post;
      iss_t        held;
      iss_t        cur;
      iss_t        e;
      res_t        r;
      logic [15:0] rfv;
      cyc = 0; run = 0; post = 0; held = '0; rfv = '0;
      dbg_sel_w[g] = 2'd0;
      forever begin
        @(negedge clk);
        cur = {instr_w[g], in1_w[g], in0_w[g], cin_w[g]};
        if (rst_pe) begin
          run = 0; post = 0; held = '0;
          for (int s = 0; s < 4; s++) begin
            dbg_sel_w[g] = 2'(s); #1; rfv[s*4 +: 4] = dbg_w[g];
          end
          chk("reset_ctrl", L, {busy_w[g], done_w[g], pc_w[g], cf_w[g]}, 0);
          chk("reset_alu", L, cur, 0);
          chk("reset_rf", L, rfv, 0);
        end else begin
          if (post) begin
            chk("busy_after_done", L, busy_w[g], 0);
            post = 0;
          end
          if (!busy_w[g]) begin
            run = 0;
          end else begin
            if (!run) begin run = 1; cyc = 0; end
            cyc++;
            if (done_w[g]) begin
              if (res_q[g].size() == 0) begin
                fail_now("unexpected_done", L);
              end else begin
                r = res_q[g].pop_front();
                chk("done_cycle", L, cyc, r.n * P - PS + 1);
                chk("pc_at_done", L, pc_w[g], r.pc);
                chk("carry_at_done", L, cf_w[g], r.c);
                for (int s = 0; s < 4; s++) begin
                  dbg_sel_w[g] = 2'(s); #1; rfv[s*4 +: 4] = dbg_w[g];
                end
                chk("rf_at_done", L, rfv, r.rf);
              end
              post = 1; run = 0;
              done_seen[g] = 1;
            end else if (cyc >= 2 && (cyc - 2) % P == 0) begin
              if (iss_q[g].size() == 0) begin
                fail_now("issue_underflow", L);
              end else begin
                e = iss_q[g].pop_front();
                chk("issue_operands", L, cur, e);
              end
              held = cur;
            end else if (cyc > 2) begin
              chk("alu_hold", L, cur, held);
            end
          end
        end
      end
    end
  end

  // Reference model: executes the program word by word from pc 0.
  task automatic model_run();
    int          pc;
    logic [15:0] w;
    iss_t        e;
    logic [4:0]  y;
    res_t        r;
    pc = 0; r = '0;
    forever begin
      w = mem[pc];
      e.op  = w[15:13];
      e.in1 = mrf[w[10:9]];
      e.in0 = w[6] ? w[5:2] : mrf[w[8:7]];
      e.cin = w[1] ? mc : 1'b0;
      for (int g = 0; g < 2; g++) iss_q[g].push_back(e);
      y = alu_f(e.op, e.in1, e.in0, e.cin);
      mrf[w[12:11]] = y[3:0];
      mc = y[4];
      r.n = r.n + 1;
      if (w[0] || pc == 15) break;
      pc++;
    end
    r.pc = 4'(pc);
    r.c  = mc;
    r.rf = {mrf[3], mrf[2], mrf[1], mrf[0]};
    for (int g = 0; g < 2; g++) res_q[g].push_back(r);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = mem[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(done_seen[0] && done_seen[1]) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!(done_seen[0] && done_seen[1])) fail_now("timeout", 0);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("issue_queue_drained", g * 2 + 1, iss_q[g].size(), 0);
      iss_q[g].delete();
      res_q[g].delete();
    end
  endtask

  task automatic run_prog(input bit wr0, input logic [15:0] w0, input bit poke);
    if (wr0) mem[0] = w0;
    model_run();
    done_seen[0] = 0; done_seen[1] = 0;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin prog_we = 1'b1; prog_addr = 4'd0; prog_data = w0; end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    if (poke) begin
      @(negedge clk);
      start = 1'b1; prog_we = 1'b1;
      prog_addr = 4'($urandom_range(0, 15)); prog_data = 16'($urandom);
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
    end
    wait_done();
  endtask

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 0) w[15:13] = 3'b001;
    w[0] = allow_halt && ($urandom_range(0, 3) == 0);
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    mc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two-instruction program: rf0 = 0+5, rf1 = rf0+2, halt.
    mem[0] = enc(1, 0, 0, 0, 1, 5, 0, 0);
    mem[1] = enc(1, 1, 0, 0, 1, 2, 0, 1);
    load_prog();
    run_prog(0, '0, 0);

    // Carry chain: rf0 = rf3+15, rf1 = rf0+1 (carry out), rf2 = rf2+0+carry.
    mem[0] = enc(1, 0, 3, 0, 1, 15, 0, 0);
    mem[1] = enc(1, 1, 0, 0, 1, 1, 0, 0);
    mem[2] = enc(1, 2, 2, 0, 1, 0, 1, 1);
    load_prog();
    run_prog(0, '0, 0);

    // No halt anywhere: run ends at pc 15; stray start and write while busy.
    for (int i = 0; i < 16; i++) mem[i] = rand_word(0);
    load_prog();
    run_prog(0, '0, 1);

    // Reset during the WAIT of instruction 1 on the ALU_LAT=3 instance.
    mem[0] = enc(1, 0, 0, 0, 1, 3, 0, 0);
    mem[1] = enc(1, 1, 0, 0, 1, 4, 0, 0);
    mem[2] = enc(1, 2, 1, 0, 0, 0, 0, 1);
    load_prog();
    model_run();
    done_seen[0] = 0; done_seen[1] = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin iss_q[g].delete(); res_q[g].delete(); end
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    mc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_reset", 0, {30'd0, done_seen[1], done_seen[0]}, 0);
    run_prog(0, '0, 0);

    // Randomized programs, some with a write landing alongside start.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = rand_word(1);
      load_prog();
      run_prog(bit'($urandom_range(0, 1)), rand_word(1), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
